// File: rtl/yuv_pkg.sv
// Shared types and geometry helpers for the YUV422P planar frame reader.
package yuv_pkg;

  localparam int unsigned PIX_W   = 10;
  localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdU,
    StRdV,
    StRdY0,
    StRdY1,
    StCap,
    StOut0,
    StOut1
  } state_e;

  // Plane sizes in bytes; the chroma planes are half width, full height.
  function automatic int unsigned y_plane_size(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned uv_plane_size(input int unsigned w, input int unsigned h);
    return h * (w / 2);
  endfunction

endpackage

// File: rtl/yuv422p_plane_reader_if.sv
// Memory read port and pixel stream of the planar frame reader.
interface yuv422p_plane_reader_if
  import yuv_pkg::*;
#(
  parameter int unsigned ADDR_W = 20
);
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              out_ready;
  logic              data_valid;
  logic [7:0]        y_data;
  logic [7:0]        u_data;
  logic [7:0]        v_data;
  logic [PIX_W-1:0]  pixel_x;
  logic [PIX_W-1:0]  pixel_y;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, mem_rd_data, out_ready,
    output mem_rd_en, mem_addr, data_valid, y_data, u_data, v_data,
           pixel_x, pixel_y, busy, frame_done
  );

  modport slave (
    output start, mem_rd_data, out_ready,
    input  mem_rd_en, mem_addr, data_valid, y_data, u_data, v_data,
           pixel_x, pixel_y, busy, frame_done
  );

endinterface

// File: rtl/yuv422p_addr_gen.sv
// Pixel-pair position counters and running plane line bases; adders only, no multipliers.
module yuv422p_addr_gen
  import yuv_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 466,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [PIX_W-1:0]  x_o,
  output logic [PIX_W-1:0]  y_o,
  output logic [ADDR_W-1:0] y0_addr_o,
  output logic [ADDR_W-1:0] y1_addr_o,
  output logic [ADDR_W-1:0] u_addr_o,
  output logic [ADDR_W-1:0] v_addr_o,
  output logic              last_pair_o
);

  localparam int unsigned Y_PLANE_SIZE  = y_plane_size(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned UV_PLANE_SIZE = uv_plane_size(IMG_WIDTH, IMG_HEIGHT);

  localparam logic [ADDR_W-1:0] YBase0     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] UvBase0    = ADDR_W'(BASE_ADDR + Y_PLANE_SIZE);
  localparam logic [ADDR_W-1:0] VOffset    = ADDR_W'(UV_PLANE_SIZE);
  localparam logic [ADDR_W-1:0] YLineStep  = ADDR_W'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] UvLineStep = ADDR_W'(IMG_WIDTH / 2);
  localparam logic [PIX_W-1:0]  LastX      = PIX_W'(IMG_WIDTH - 2);
  localparam logic [PIX_W-1:0]  LastY      = PIX_W'(IMG_HEIGHT - 1);

  logic [PIX_W-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] y_base_q, y_base_d, uv_base_q, uv_base_d;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    y_base_d  = y_base_q;
    uv_base_d = uv_base_q;
    if (clear_i) begin
      x_d       = '0;
      y_d       = '0;
      y_base_d  = YBase0;
      uv_base_d = UvBase0;
    end else if (advance_i) begin
      if (x_q == LastX) begin
        x_d       = '0;
        y_d       = y_q + PIX_W'(1);
        y_base_d  = y_base_q + YLineStep;
        uv_base_d = uv_base_q + UvLineStep;
      end else begin
        x_d = x_q + PIX_W'(2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      y_base_q  <= YBase0;
      uv_base_q <= UvBase0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      y_base_q  <= y_base_d;
      uv_base_q <= uv_base_d;
    end
  end

  // x is always even, so Y(x+1) just sets the low bit of the column offset.
  assign y0_addr_o   = y_base_q + ADDR_W'(x_q);
  assign y1_addr_o   = y_base_q + ADDR_W'({x_q[PIX_W-1:1], 1'b1});
  assign u_addr_o    = uv_base_q + ADDR_W'(x_q >> 1);
  assign v_addr_o    = u_addr_o + VOffset;
  assign last_pair_o = (x_q == LastX) && (y_q == LastY);
  assign x_o         = x_q;
  assign y_o         = y_q;

endmodule

// File: rtl/yuv422p_plane_reader.sv
// Reads a YUV422P frame from byte-wide synchronous memory and streams pixels in raster order.
module yuv422p_plane_reader
  import yuv_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 466,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned BASE_ADDR  = 0
) (
  input logic                     clk,
  input logic                     rst,
  yuv422p_plane_reader_if.master  bus
);

  if (IMG_WIDTH > PIX_MAX || IMG_HEIGHT > PIX_MAX || IMG_WIDTH < 2 || IMG_HEIGHT < 1 ||
      (IMG_WIDTH % 2) != 0) begin : g_geom_check
    $error("yuv422p_plane_reader: unsupported frame geometry");
  end

  state_e            state_q, state_d;
  logic              clear, advance, last_pair;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr, mem_addr_q;
  logic [ADDR_W-1:0] y0_addr, y1_addr, u_addr, v_addr;
  logic [PIX_W-1:0]  x, y;
  logic [7:0]        u_q, v_q, y0_q, y1_q;
  logic              busy_q, busy_d, done_q, done_d;

  yuv422p_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .advance_i   (advance),
    .x_o         (x),
    .y_o         (y),
    .y0_addr_o   (y0_addr),
    .y1_addr_o   (y1_addr),
    .u_addr_o    (u_addr),
    .v_addr_o    (v_addr),
    .last_pair_o (last_pair)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRdU;
          clear   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StRdU:  state_d = StRdV;
      StRdV:  state_d = StRdY0;
      StRdY0: state_d = StRdY1;
      StRdY1: state_d = StCap;
      StCap:  state_d = StOut0;
      StOut0: if (bus.out_ready) state_d = StOut1;
      StOut1: begin
        if (bus.out_ready) begin
          if (last_pair) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            advance = 1'b1;
            state_d = StRdU;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Address is driven straight from the counters while reading, held otherwise.
  always_comb begin
    rd_en   = 1'b1;
    rd_addr = mem_addr_q;
    case (state_q)
      StRdU:   rd_addr = u_addr;
      StRdV:   rd_addr = v_addr;
      StRdY0:  rd_addr = y0_addr;
      StRdY1:  rd_addr = y1_addr;
      default: rd_en   = 1'b0;
    endcase
  end

  // Each state captures the byte requested by the previous state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_addr_q <= '0;
      u_q        <= '0;
      v_q        <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= rd_addr;
      busy_q     <= busy_d;
      done_q     <= done_d;
      case (state_q)
        StRdV:   u_q  <= bus.mem_rd_data;
        StRdY0:  v_q  <= bus.mem_rd_data;
        StRdY1:  y0_q <= bus.mem_rd_data;
        StCap:   y1_q <= bus.mem_rd_data;
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = rd_addr;
  assign bus.data_valid = (state_q == StOut0) || (state_q == StOut1);
  assign bus.y_data     = (state_q == StOut1) ? y1_q : y0_q;
  assign bus.u_data     = u_q;
  assign bus.v_data     = v_q;
  assign bus.pixel_x    = {x[PIX_W-1:1], state_q == StOut1};
  assign bus.pixel_y    = y;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
